// File: rtl/uart_receiver.sv
// uart_receiver
// Receive side of the UART link. Deserialises 11-bit frames
// (start=0, 8 data bits MSB first, even parity, stop=1) into one byte per frame
// and reports parity and framing status alongside it.
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst_n       synchronous active-low reset
//   rx_in       serial line, idle high (same clock domain as the transmitter)
//   data_out    last received byte, held until the next completed frame
//   data_valid  one-cycle pulse when a frame completes
//   parity_err  qualifies data_valid: parity mismatch
//   frame_err   qualifies data_valid: stop bit sampled low
//   busy        high from start detection through the stop-bit sample
//
// State  | meaning
// -------+------------------------------------------------------------
// IDLE   | line idle, waiting for a low sample
// START  | start bit seen, waiting for the mid-bit verification sample
// DATA   | shifting in 8 data bits, MSB first
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit, publishing byte and status
// BREAK  | stop bit was low; wait for the line to return high

module uart_receiver #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT) + 1;

    // Sample timer is a down-counter; a sample is taken when it reaches zero.
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'((HALF > 0) ? (HALF - 1) : 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          par_bit, par_bit_nxt;
    logic [7:0]    data_out_nxt;
    logic          data_valid_nxt, parity_err_nxt, frame_err_nxt;
    logic          tick;

    assign tick = (cnt == '0);
    assign busy = (state == START) || (state == DATA) ||
                  (state == PARITY) || (state == STOP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            shift      <= shift_nxt;
            par_bit    <= par_bit_nxt;
            data_out   <= data_out_nxt;
            data_valid <= data_valid_nxt;
            parity_err <= parity_err_nxt;
            frame_err  <= frame_err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = tick ? cnt : (cnt - CW'(1));
        bit_idx_nxt    = bit_idx;
        shift_nxt      = shift;
        par_bit_nxt    = par_bit;
        data_out_nxt   = data_out;
        data_valid_nxt = 1'b0;
        parity_err_nxt = 1'b0;
        frame_err_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_in) begin
                    bit_idx_nxt = '0;
                    // With no room for a mid-bit sample the detection sample
                    // doubles as the verification sample.
                    if (HALF == 0) begin
                        state_nxt = DATA;
                        cnt_nxt   = BIT_LOAD;
                    end else begin
                        state_nxt = START;
                        cnt_nxt   = HALF_LOAD;
                    end
                end
            end
            START: begin
                if (tick) begin
                    if (rx_in) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt   = DATA;
                        cnt_nxt     = BIT_LOAD;
                        bit_idx_nxt = '0;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_nxt   = {shift[6:0], rx_in};
                    cnt_nxt     = BIT_LOAD;
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = PARITY;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    par_bit_nxt = rx_in;
                    cnt_nxt     = BIT_LOAD;
                    state_nxt   = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    data_out_nxt   = shift;
                    parity_err_nxt = ^{shift, par_bit};
                    frame_err_nxt  = ~rx_in;
                    data_valid_nxt = 1'b1;
                    // A low stop bit means the line may be held in break;
                    // don't treat that low level as a new start bit.
                    state_nxt      = rx_in ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rx_in) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

    logic       clk;
    logic       rst_n;
    logic       rx1, rx16;
    logic [7:0] data_out1, data_out16;
    logic       data_valid1, parity_err1, frame_err1, busy1;
    logic       data_valid16, parity_err16, frame_err16, busy16;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         cyc;
    } exp_t;

    exp_t exp_q1[$];
    exp_t exp_q16[$];

    typedef struct {
        logic [7:0] data;
        logic       pflip;
        logic       stop;
        int         low_after;
        int         idle_after;
        logic       eperr;
        logic       eferr;
    } vec_t;

    vec_t vecs[11];

    uart_receiver #(.CLKS_PER_BIT(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_in      (rx1),
        .data_out   (data_out1),
        .data_valid (data_valid1),
        .parity_err (parity_err1),
        .frame_err  (frame_err1),
        .busy       (busy1)
    );

    uart_receiver #(.CLKS_PER_BIT(16)) dut16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_in      (rx16),
        .data_out   (data_out16),
        .data_valid (data_valid16),
        .parity_err (parity_err16),
        .frame_err  (frame_err16),
        .busy       (busy16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_pulse(input string name, input exp_t q[$], output exp_t rest[$],
                               input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        rest = q;
        n_cmp++;
        if (rest.size() == 0) begin
            n_err++;
            $display("FAIL %s unexpected_pulse: got data=0x%0h perr=%0b ferr=%0b, expected no pulse (cycle %0d)",
                     name, d, pe, fe, cyc);
        end else begin
            e = rest.pop_front();
            if (d !== e.data || pe !== e.perr || fe !== e.ferr || (e.cyc >= 0 && e.cyc != cyc)) begin
                n_err++;
                $display("FAIL %s pulse: got data=0x%0h perr=%0b ferr=%0b cyc=%0d, expected data=0x%0h perr=%0b ferr=%0b cyc=%0d",
                         name, d, pe, fe, cyc, e.data, e.perr, e.ferr, e.cyc);
            end
        end
    endtask

    // Scoreboard monitors: pop one expected frame per data_valid pulse.
    always @(negedge clk) begin
        exp_t rest[$];
        if (data_valid1 === 1'b1) begin
            check_pulse("cpb1", exp_q1, rest, data_out1, parity_err1, frame_err1);
            exp_q1 = rest;
        end
    end

    always @(negedge clk) begin
        exp_t rest[$];
        if (data_valid16 === 1'b1) begin
            check_pulse("cpb16", exp_q16, rest, data_out16, parity_err16, frame_err16);
            exp_q16 = rest;
        end
    end

    task automatic set_rx(input int sel, input logic b);
        if (sel == 16) rx16 = b;
        else           rx1  = b;
    endtask

    // Called at a negedge; each bit is held for cpb clocks.
    task automatic send_frame(input int sel, input logic [7:0] d, input logic pflip,
                              input logic stop, input int low_after, input int idle_after,
                              input logic eperr, input logic eferr, input logic chk_busy);
        int          cpb;
        logic [10:0] bits;
        exp_t        e;
        cpb  = (sel == 16) ? 16 : 1;
        bits = {1'b0, d, (^d) ^ pflip, stop};
        for (int k = 10; k >= 0; k--) begin
            if (chk_busy) check($sformatf("busy_bit%0d", 10 - k), {31'd0, busy1}, {31'd0, k != 10});
            if (k == 0) begin
                e.data = d;
                e.perr = eperr;
                e.ferr = eferr;
                e.cyc  = (sel == 16) ? -1 : cyc + 1;
                if (sel == 16) exp_q16.push_back(e);
                else           exp_q1.push_back(e);
            end
            set_rx(sel, bits[k]);
            repeat (cpb) @(negedge clk);
        end
        if (chk_busy) check("busy_after_stop", {31'd0, busy1}, 32'd0);
        for (int i = 0; i < low_after; i++) begin
            if (sel == 1) check("busy_in_break", {31'd0, busy1}, 32'd0);
            set_rx(sel, 1'b0);
            @(negedge clk);
        end
        set_rx(sel, 1'b1);
        repeat (idle_after) @(negedge clk);
    endtask

    initial begin
        logic [7:0] partial;

        vecs[0]  = '{8'hA5, 1'b0, 1'b1, 0, 3, 1'b0, 1'b0};
        vecs[1]  = '{8'hA5, 1'b1, 1'b1, 0, 3, 1'b1, 1'b0};
        vecs[2]  = '{8'h3C, 1'b0, 1'b0, 5, 2, 1'b0, 1'b1};
        vecs[3]  = '{8'hFF, 1'b0, 1'b1, 0, 3, 1'b0, 1'b0};
        vecs[4]  = '{8'h3C, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0};
        vecs[5]  = '{8'h81, 1'b0, 1'b1, 0, 2, 1'b0, 1'b0};
        vecs[6]  = '{8'h3C, 1'b0, 1'b1, 0, 2, 1'b0, 1'b0};
        vecs[7]  = '{8'h81, 1'b0, 1'b1, 0, 3, 1'b0, 1'b0};
        vecs[8]  = '{8'h00, 1'b0, 1'b1, 0, 2, 1'b0, 1'b0};
        vecs[9]  = '{8'hFF, 1'b0, 1'b1, 0, 2, 1'b0, 1'b0};
        vecs[10] = '{8'h55, 1'b0, 1'b1, 0, 5, 1'b0, 1'b0};

        rst_n = 1'b0;
        rx1   = 1'b1;
        rx16  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data_out",   {24'd0, data_out1}, 32'd0);
        check("rst_data_valid", {31'd0, data_valid1}, 32'd0);
        check("rst_parity_err", {31'd0, parity_err1}, 32'd0);
        check("rst_frame_err",  {31'd0, frame_err1}, 32'd0);
        check("rst_busy",       {31'd0, busy1}, 32'd0);
        check("rst16_data_out", {24'd0, data_out16}, 32'd0);
        check("rst16_busy",     {31'd0, busy16}, 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_busy", {31'd0, busy1}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            send_frame(1, vecs[i].data, vecs[i].pflip, vecs[i].stop, vecs[i].low_after,
                       vecs[i].idle_after, vecs[i].eperr, vecs[i].eferr, i == 0);
        end
        check("hold_data_out",   {24'd0, data_out1}, 32'h55);
        check("hold_data_valid", {31'd0, data_valid1}, 32'd0);
        check("hold_parity_err", {31'd0, parity_err1}, 32'd0);

        // Reset while data bit 4 (fifth data bit, MSB first) is on the line.
        partial = 8'h5A;
        rx1 = 1'b0;
        @(negedge clk);
        for (int b = 7; b >= 4; b--) begin
            rx1 = partial[b];
            @(negedge clk);
        end
        rst_n = 1'b0;
        rx1   = partial[3];
        @(negedge clk);
        rst_n = 1'b1;
        rx1   = 1'b1;
        repeat (15) @(negedge clk);
        check("midrst_busy",     {31'd0, busy1}, 32'd0);
        check("midrst_data_out", {24'd0, data_out1}, 32'd0);
        send_frame(1, 8'h5A, 1'b0, 1'b1, 0, 4, 1'b0, 1'b0, 1'b0);

        // Slow receiver: short glitch must be rejected at the mid-bit check.
        rx16 = 1'b0;
        @(negedge clk);
        check("glitch_busy_start", {31'd0, busy16}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rx16 = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_busy_end", {31'd0, busy16}, 32'd0);
        send_frame(16, 8'hC3, 1'b0, 1'b1, 0, 20, 1'b0, 1'b0, 1'b0);
        check("cpb16_busy_end", {31'd0, busy16}, 32'd0);

        for (int i = 0; i < 400 && (exp_q1.size() != 0 || exp_q16.size() != 0); i++) begin
            @(negedge clk);
        end
        check("pending_cpb1",  exp_q1.size(), 32'd0);
        check("pending_cpb16", exp_q16.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
